// File: rtl/stream_mux_arbiter_if.sv
// Stream mux/arbiter bus: per-channel valid/last/data inputs, one handshaked output.
interface stream_mux_arbiter_if #(
    parameter int unsigned CHANNELS_COUNT = 5,
    parameter int unsigned CHANNELS_WIDTH = 4
);
    localparam int unsigned SEL_W = (CHANNELS_COUNT > 1) ? $clog2(CHANNELS_COUNT) : 1;

    logic [SEL_W-1:0]                              select;
    logic [CHANNELS_COUNT-1:0]                     in_valid;
    logic [CHANNELS_COUNT-1:0]                     in_last;
    logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0] in_data;
    logic [CHANNELS_COUNT-1:0]                     in_ready;
    logic                                          out_valid;
    logic                                          out_last;
    logic [CHANNELS_WIDTH-1:0]                     out_data;
    logic [SEL_W-1:0]                              out_channel;
    logic                                          out_ready;

    // Producers plus consumer side (drives inputs and out_ready).
    modport master (
        output select, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_channel
    );

    // The mux/arbiter itself.
    modport slave (
        input  select, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_channel
    );
endinterface

// File: rtl/stream_mux_arbiter.sv
// Packet-locked stream multiplexer with a registered output stage.
// MODE=0 picks the channel from select, MODE=1 uses round-robin arbitration.
module stream_mux_arbiter #(
    parameter int unsigned CHANNELS_COUNT = 5,
    parameter int unsigned CHANNELS_WIDTH = 4,
    parameter int unsigned MODE           = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_mux_arbiter_if.slave  sif
);
    localparam int unsigned SEL_W = (CHANNELS_COUNT > 1) ? $clog2(CHANNELS_COUNT) : 1;
    localparam int unsigned CW    = CHANNELS_WIDTH;
    localparam int unsigned CC    = CHANNELS_COUNT;

    // Parameter sanity checks at elaboration.
    if (CHANNELS_COUNT < 2) begin : g_bad_count
        $fatal(1, "stream_mux_arbiter: CHANNELS_COUNT must be >= 2");
    end
    if (CHANNELS_WIDTH < 1) begin : g_bad_width
        $fatal(1, "stream_mux_arbiter: CHANNELS_WIDTH must be >= 1");
    end
    if (MODE > 1) begin : g_bad_mode
        $fatal(1, "stream_mux_arbiter: MODE must be 0 or 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] rr_pick_c;
    logic [SEL_W-1:0] rr_next_c;
    logic             rr_any_c;
    logic             sel_ok_c;
    logic             stage_free_c;
    logic             accept_c;
    logic             beat_last_c;
    logic [CW-1:0]    beat_data_c;
    logic [CC-1:0]    in_ready_c;

    logic             out_valid_q;
    logic             out_last_q;
    logic [CW-1:0]    out_data_q;
    logic [SEL_W-1:0] out_channel_q;

    // Round-robin search: first valid channel starting at rr_ptr, wrapping modulo CC.
    always_comb begin : rr_search
        logic [SEL_W-1:0] idx;
        rr_pick_c = '0;
        rr_any_c  = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < CC; i++) begin
            idx = SEL_W'((32'(rr_ptr_q) + i) % CC);
            if (!rr_any_c && sif.in_valid[idx]) begin
                rr_any_c  = 1'b1;
                rr_pick_c = idx;
            end
        end
    end

    // Handshake decode: output-stage availability, per-channel ready, accepted beat.
    always_comb begin
        sel_ok_c     = (32'(sif.select) < CC);
        stage_free_c = !out_valid_q || sif.out_ready;
        in_ready_c   = '0;
        for (int unsigned g = 0; g < CC; g++) begin
            in_ready_c[g] = stage_free_c && (state_q == ST_LOCKED) && (grant_q == SEL_W'(g));
        end
        accept_c    = |(sif.in_valid & in_ready_c);
        beat_last_c = sif.in_last[grant_q];
        beat_data_c = sif.in_data[grant_q];
        rr_next_c   = (32'(grant_q) == CC - 1) ? '0 : grant_q + SEL_W'(1);
    end

    // Grant FSM next state: lock on a request, release after the granted packet's last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (MODE == 0) begin
                    if (sel_ok_c) begin
                        state_d = ST_LOCKED;
                        grant_d = sif.select;
                    end
                end else if (rr_any_c) begin
                    state_d = ST_LOCKED;
                    grant_d = rr_pick_c;
                end
            end
            ST_LOCKED: begin
                if (accept_c && beat_last_c) begin
                    state_d = ST_IDLE;
                    if (MODE == 1) begin
                        rr_ptr_d = rr_next_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output pipeline register; the output beat only moves when the stage is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (stage_free_c) begin
                out_valid_q <= accept_c;
                if (accept_c) begin
                    out_last_q    <= beat_last_c;
                    out_data_q    <= beat_data_c;
                    out_channel_q <= grant_q;
                end
            end
        end
    end

    assign sif.in_ready    = in_ready_c;
    assign sif.out_valid   = out_valid_q;
    assign sif.out_last    = out_last_q;
    assign sif.out_data    = out_data_q;
    assign sif.out_channel = out_channel_q;
endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed bench: one MODE=0 and one MODE=1 instance, five channels of 4-bit data.
module tb_stream_mux_arbiter;
    logic clk = 1'b0;
    logic rst0_n = 1'b1;
    logic rst1_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    stream_mux_arbiter_if #(.CHANNELS_COUNT(5), .CHANNELS_WIDTH(4)) if0 ();
    stream_mux_arbiter_if #(.CHANNELS_COUNT(5), .CHANNELS_WIDTH(4)) if1 ();

    stream_mux_arbiter #(.CHANNELS_COUNT(5), .CHANNELS_WIDTH(4), .MODE(0)) u_sel (
        .clk   (clk),
        .rst_n (rst0_n),
        .sif   (if0)
    );

    stream_mux_arbiter #(.CHANNELS_COUNT(5), .CHANNELS_WIDTH(4), .MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst1_n),
        .sif   (if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] cnt;
        logic [4:0] acc;
        int         idx;
        int         exp_ch [12];
        exp_ch = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};

        if0.select = 3'd7; if0.in_valid = '0; if0.in_last = '0; if0.in_data = '0; if0.out_ready = 1'b1;
        if1.select = 3'd0; if1.in_valid = '0; if1.in_last = '0; if1.in_data = '0; if1.out_ready = 1'b1;

        // Asynchronous reset before the first clock edge
        #2; rst0_n = 1'b0; rst1_n = 1'b0;
        #1;
        chk("rst_out_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data0",  32'(if0.out_data),  32'd0);
        chk("rst_in_ready0",  32'(if0.in_ready),  32'd0);
        chk("rst_out_valid1", 32'(if1.out_valid), 32'd0);
        chk("rst_in_ready1",  32'(if1.in_ready),  32'd0);
        @(negedge clk); rst0_n = 1'b1; rst1_n = 1'b1;
        tick();
        chk("idle_in_ready0", 32'(if0.in_ready), 32'd0);
        chk("idle_in_ready1", 32'(if1.in_ready), 32'd0);

        // MODE=0: select out of range never grants
        if0.in_valid = 5'b11111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("oor_in_ready",  32'(if0.in_ready),  32'd0);
            chk("oor_out_valid", 32'(if0.out_valid), 32'd0);
        end
        if0.in_valid = '0;

        // MODE=0: channel 2 sends A, B, C(last)
        if0.select = 3'd2; if0.in_valid = 5'b00100; if0.in_data[2] = 4'hA; if0.in_last[2] = 1'b0;
        tick();
        chk("basic_lock_ready", 32'(if0.in_ready),  32'b00100);
        chk("basic_lock_valid", 32'(if0.out_valid), 32'd0);
        tick();
        chk("basic_a_valid", 32'(if0.out_valid),   32'd1);
        chk("basic_a_data",  32'(if0.out_data),    32'hA);
        chk("basic_a_ch",    32'(if0.out_channel), 32'd2);
        chk("basic_a_last",  32'(if0.out_last),    32'd0);
        if0.in_data[2] = 4'hB;
        tick();
        chk("basic_b_data", 32'(if0.out_data), 32'hB);
        chk("basic_b_last", 32'(if0.out_last), 32'd0);
        if0.in_data[2] = 4'hC; if0.in_last[2] = 1'b1;
        tick();
        chk("basic_c_data",  32'(if0.out_data),    32'hC);
        chk("basic_c_last",  32'(if0.out_last),    32'd1);
        chk("basic_c_ch",    32'(if0.out_channel), 32'd2);
        chk("basic_c_ready", 32'(if0.in_ready),    32'd0);
        if0.select = 3'd7; if0.in_valid = '0; if0.in_last = '0;
        tick();
        chk("basic_drain", 32'(if0.out_valid), 32'd0);

        // MODE=0 backpressure: channel 3 sends 1, 2, 3(last), stall 4 cycles after beat 1
        if0.select = 3'd3; if0.in_valid = 5'b01000; if0.in_data[3] = 4'h1;
        tick();
        chk("bp_lock_ready", 32'(if0.in_ready), 32'b01000);
        tick();
        chk("bp_1_data", 32'(if0.out_data), 32'h1);
        if0.in_data[3] = 4'h2; if0.out_ready = 1'b0;
        #1;
        chk("bp_stall_ready", 32'(if0.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(if0.out_valid), 32'd1);
            chk("bp_hold_data",  32'(if0.out_data),  32'h1);
            chk("bp_hold_ready", 32'(if0.in_ready),  32'd0);
        end
        if0.out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(if0.in_ready), 32'b01000);
        tick();
        chk("bp_2_data", 32'(if0.out_data), 32'h2);
        chk("bp_2_last", 32'(if0.out_last), 32'd0);
        if0.in_data[3] = 4'h3; if0.in_last[3] = 1'b1;
        tick();
        chk("bp_3_data", 32'(if0.out_data), 32'h3);
        chk("bp_3_last", 32'(if0.out_last), 32'd1);
        if0.select = 3'd7; if0.in_valid = '0; if0.in_last = '0;
        tick();
        chk("bp_drain", 32'(if0.out_valid), 32'd0);

        // MODE=0 packet lock: select moves 1 -> 4 mid-packet
        if0.select = 3'd1; if0.in_valid = 5'b10010;
        if0.in_data[1] = 4'h5; if0.in_data[4] = 4'h9; if0.in_last[4] = 1'b1;
        tick();
        chk("lock_ready_1", 32'(if0.in_ready), 32'b00010);
        if0.select = 3'd4;
        tick();
        chk("lock_5_data",  32'(if0.out_data),    32'h5);
        chk("lock_5_ch",    32'(if0.out_channel), 32'd1);
        chk("lock_ready_2", 32'(if0.in_ready),    32'b00010);
        if0.in_data[1] = 4'h6;
        tick();
        chk("lock_6_data", 32'(if0.out_data),    32'h6);
        chk("lock_6_ch",   32'(if0.out_channel), 32'd1);
        if0.in_data[1] = 4'h7; if0.in_last[1] = 1'b1;
        tick();
        chk("lock_7_data",   32'(if0.out_data),    32'h7);
        chk("lock_7_last",   32'(if0.out_last),    32'd1);
        chk("lock_7_ch",     32'(if0.out_channel), 32'd1);
        chk("lock_idle_rdy", 32'(if0.in_ready),    32'd0);
        if0.in_valid = 5'b10000; if0.in_last[1] = 1'b0;
        tick();
        chk("lock_gap_valid", 32'(if0.out_valid), 32'd0);
        chk("lock_ready_4",   32'(if0.in_ready),  32'b10000);
        tick();
        chk("lock_9_data", 32'(if0.out_data),    32'h9);
        chk("lock_9_ch",   32'(if0.out_channel), 32'd4);
        chk("lock_9_last", 32'(if0.out_last),    32'd1);
        if0.select = 3'd7; if0.in_valid = '0; if0.in_last = '0;
        tick();
        chk("lock_drain", 32'(if0.out_valid), 32'd0);

        // MODE=0 asynchronous reset mid-packet with a beat in the output stage
        if0.select = 3'd0; if0.in_valid = 5'b00001; if0.in_data[0] = 4'hE;
        tick();
        tick();
        chk("mrst_pre_data",  32'(if0.out_data), 32'hE);
        chk("mrst_pre_ready", 32'(if0.in_ready), 32'b00001);
        #2; rst0_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(if0.out_valid),   32'd0);
        chk("mrst_out_data",  32'(if0.out_data),    32'd0);
        chk("mrst_out_ch",    32'(if0.out_channel), 32'd0);
        chk("mrst_in_ready",  32'(if0.in_ready),    32'd0);
        if0.select = 3'd7; if0.in_valid = '0;
        @(negedge clk); rst0_n = 1'b1;
        tick();
        chk("mrst_after_valid", 32'(if0.out_valid), 32'd0);
        chk("mrst_after_ready", 32'(if0.in_ready),  32'd0);

        // MODE=1 fairness: channels 0, 1, 3 always valid, two-beat packets
        cnt = '0; idx = 0;
        if1.in_valid = 5'b01011;
        for (int cyc = 0; cyc < 40 && idx < 12; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                if1.in_data[c] = 4'(c * 4 + int'(cnt[c]));
                if1.in_last[c] = cnt[c];
            end
            #1;
            acc = if1.in_valid & if1.in_ready;
            tick();
            cnt = cnt ^ acc;
            if (if1.out_valid) begin
                chk("rr_ch",   32'(if1.out_channel), 32'(exp_ch[idx]));
                chk("rr_data", 32'(if1.out_data),    32'(exp_ch[idx] * 4 + idx % 2));
                chk("rr_last", 32'(if1.out_last),    32'(idx % 2));
                idx++;
            end
        end
        chk("rr_beat_count", 32'(idx), 32'd12);
        if1.in_valid = '0; if1.in_last = '0;

        // MODE=1 reset mid-packet: pointer sits at 4, after reset the search restarts at 0
        if1.in_valid = 5'b10010; if1.in_data[1] = 4'h1; if1.in_data[4] = 4'h4;
        tick();
        chk("rrst_lock_ready", 32'(if1.in_ready), 32'b10000);
        tick();
        chk("rrst_pre_ch",   32'(if1.out_channel), 32'd4);
        chk("rrst_pre_data", 32'(if1.out_data),    32'h4);
        #2; rst1_n = 1'b0;
        #1;
        chk("rrst_out_valid", 32'(if1.out_valid),   32'd0);
        chk("rrst_out_data",  32'(if1.out_data),    32'd0);
        chk("rrst_out_ch",    32'(if1.out_channel), 32'd0);
        chk("rrst_in_ready",  32'(if1.in_ready),    32'd0);
        @(negedge clk); rst1_n = 1'b1;
        tick();
        chk("rrst_regrant", 32'(if1.in_ready), 32'b00010);
        tick();
        chk("rrst_new_ch",    32'(if1.out_channel), 32'd1);
        chk("rrst_new_data",  32'(if1.out_data),    32'h1);
        chk("rrst_new_valid", 32'(if1.out_valid),   32'd1);
        if1.in_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_mux_arbiter.md
Name: stream_mux_arbiter

Overview:
- Registered, handshaked successor to the combinational M×N multiplexer.
- Selects one of CHANNELS_COUNT valid/ready input streams and forwards it through a single output pipeline register.
- Channel choice comes from an external select (MODE=0) or from an internal round-robin arbiter (MODE=1).
- The grant is held for a whole packet, delimited by a last flag, so beats from different channels never interleave.
- Sits between multiple producers and one shared consumer, for example a shared bus or FIFO write port.

Parameters:
- CHANNELS_COUNT, 5, number of input streams; must be >= 2 (fatal at elaboration otherwise).
- CHANNELS_WIDTH, 4, data bits per channel; must be >= 1 (fatal otherwise).
- MODE, 0, 0 = external select, 1 = round-robin arbitration; any other value is fatal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- select  in  $clog2(CHANNELS_COUNT)  channel request in MODE=0; ignored in MODE=1.
- in_valid  in  CHANNELS_COUNT  per-channel beat valid.
- in_last  in  CHANNELS_COUNT  per-channel end-of-packet flag, qualified by in_valid.
- in_data  in  [CHANNELS_COUNT][CHANNELS_WIDTH]  per-channel data, packed array.
- in_ready  out  CHANNELS_COUNT  per-channel ready; at most one bit set.
- out_valid  out  1  output beat valid.
- out_last  out  1  output end-of-packet.
- out_data  out  CHANNELS_WIDTH  output data.
- out_channel  out  $clog2(CHANNELS_COUNT)  index of the channel that produced the current output beat.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_last=0, out_data=0, out_channel=0, FSM=IDLE, rr_ptr=0.
  - in_ready is all-zero while in reset and in IDLE.
- Transfer rule: a beat transfers when valid & ready are both high on a rising edge.
  - Upstream: in_valid[g] & in_ready[g].
  - Downstream: out_valid & out_ready.
- Output register: stage_free = !out_valid | out_ready.
  - in_ready[g] = stage_free & (FSM==LOCKED) & (g==grant).
  - All other in_ready bits are 0. in_ready is combinational from out_ready.
- Latency: an accepted beat appears on the outputs the next cycle.
  - Full throughput: one beat per cycle while out_ready stays high.
  - When stage_free and no input beat is accepted, out_valid clears on the next edge.
- FSM, IDLE -> LOCKED:
  - MODE=0: transition when select < CHANNELS_COUNT; grant = select.
  - MODE=0, select >= CHANNELS_COUNT: no grant; remain IDLE.
  - MODE=1: transition when any in_valid is set. grant = first channel with in_valid set, searching rr_ptr, rr_ptr+1, … modulo CHANNELS_COUNT.
  - The IDLE->LOCKED transition takes one cycle; no beat is accepted in IDLE.
- FSM, LOCKED -> IDLE: when the granted channel transfers a beat with in_last=1.
  - MODE=1: on that same edge, rr_ptr = (grant+1) mod CHANNELS_COUNT.
- FSM, LOCKED otherwise:
  - grant is frozen.
  - select changes are ignored until the packet ends.
  - Other channels' in_valid are ignored.
- Single-beat packet (in_last=1 on the first beat): legal. Sequence is IDLE -> LOCKED -> IDLE, with one beat transferred.
- out_channel and out_last are registered together with out_data on each accepted beat.
- Output hold: while out_valid & !out_ready, out_data, out_last and out_channel are held stable.
- Reset mid-packet: the in-flight output beat is dropped, the FSM returns to IDLE and rr_ptr returns to 0. No partial state survives.
- Deadlock: if the granted channel never asserts in_last, the grant is held indefinitely. This is intended behaviour; no timeout.

Test Plan:
- Reset value check: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0, in_ready=0 immediately; FSM=IDLE after release.
- MODE=0 basic transfer: select=2; channel 2 sends beats 0xA, 0xB, 0xC with last on 0xC; out_ready=1.
  - out_data = A, B, C on consecutive cycles, each one cycle after its accept.
  - out_channel=2; out_last high only with C.
- MODE=0 out of range: CHANNELS_COUNT=5, select=7, all in_valid=1 -> in_ready stays 0 and out_valid stays 0 for 10 cycles.
- MODE=1 fairness: channels 0, 1 and 3 continuously valid, each sending 2-beat packets.
  - Grant order 0, 1, 3, 0, 1, 3; no interleaving within a packet.
- Backpressure: out_ready=0 for 4 cycles mid-packet.
  - out_valid=1 and out_data held for all 4 cycles.
  - in_ready[grant]=0 during the stall; no beat lost or duplicated after out_ready returns to 1.
- Packet lock and reset mid-packet:
  - MODE=0: change select from 1 to 4 mid-packet on channel 1 -> remaining beats still come from channel 1; channel 4 is granted only after channel 1's last beat.
  - MODE=1: pulse rst_n low mid-packet -> outputs return to reset values and the next grant starts from channel 0.
